// File: rtl/comp_bist.sv
// Built-in self-test for a WIDTH-bit magnitude comparator: sweeps every (a,b) pair,
// checks the {agtb,aeqb,altb} flags and records error count and the first failing vector.
module comp_bist #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    input  logic                 agtb_in,
    input  logic                 aeqb_in,
    input  logic                 altb_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_count,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b,
    output logic [2:0]           fail_flags
);
    localparam int VW = 2 * WIDTH;
    localparam int EW = VW + 1;
    localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t          state_reg;
    logic [VW-1:0]   v_reg;
    logic [CW-1:0]   settle_reg;

    logic [2:0]      exp_flags;
    logic [2:0]      obs_flags;
    logic            mismatch;
    logic            sample;
    logic            last_vec;
    logic [EW-1:0]   err_next;

    // Operands come straight from the vector register, so they are registered outputs.
    assign a_out = v_reg[VW-1:WIDTH];
    assign b_out = v_reg[WIDTH-1:0];

    always_comb begin
        exp_flags = {a_out > b_out, a_out == b_out, a_out < b_out};
        obs_flags = {agtb_in, aeqb_in, altb_in};
        mismatch  = (obs_flags != exp_flags);
        sample    = (settle_reg == CW'(LATENCY));
        last_vec  = &v_reg;
        err_next  = err_count;
        if (mismatch && !(&err_count))
            err_next = err_count + EW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            v_reg      <= '0;
            settle_reg <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_flags <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg  <= RUN;
                        v_reg      <= '0;
                        settle_reg <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                        fail_flags <= '0;
                    end
                end
                RUN: begin
                    if (sample) begin
                        settle_reg <= '0;
                        err_count  <= err_next;
                        // A zero count before this sample means this is the first failure.
                        if (mismatch && (err_count == '0)) begin
                            fail_a     <= a_out;
                            fail_b     <= b_out;
                            fail_flags <= obs_flags;
                        end
                        if (last_vec) begin
                            state_reg <= FINISH;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pass      <= (err_next == '0);
                        end else begin
                            v_reg <= v_reg + VW'(1);
                        end
                    end else begin
                        settle_reg <= settle_reg + CW'(1);
                    end
                end
                FINISH: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_comp_bist.sv
// Directed bench for comp_bist: a combinational comparator model with injectable faults,
// and a two-stage registered comparator model driving a LATENCY=2 instance.
module tb_comp_bist;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [3:0] a0, b0, a1, b1;
    logic       agtb0, aeqb0, altb0;
    logic [2:0] s1_reg, s2_reg;
    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [8:0] err0, err1;
    logic [3:0] fa0, fb0, fa1, fb1;
    logic [2:0] ff0, ff1;
    int         mode = 0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    comp_bist #(.WIDTH(4), .LATENCY(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a_out(a0), .b_out(b0),
        .agtb_in(agtb0), .aeqb_in(aeqb0), .altb_in(altb0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_a(fa0), .fail_b(fb0), .fail_flags(ff0)
    );

    comp_bist #(.WIDTH(4), .LATENCY(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a_out(a1), .b_out(b1),
        .agtb_in(s2_reg[2]), .aeqb_in(s2_reg[1]), .altb_in(s2_reg[0]),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_a(fa1), .fail_b(fb1), .fail_flags(ff1)
    );

    // Comparator models: mode selects correct / agtb stuck 0 / gt-lt swapped / all ones.
    always_comb begin
        case (mode)
            1:       {agtb0, aeqb0, altb0} = {1'b0, a0 == b0, a0 < b0};
            2:       {agtb0, aeqb0, altb0} = {a0 < b0, a0 == b0, a0 > b0};
            3:       {agtb0, aeqb0, altb0} = 3'b111;
            default: {agtb0, aeqb0, altb0} = {a0 > b0, a0 == b0, a0 < b0};
        endcase
    end

    always_ff @(posedge clk) begin
        s1_reg <= {a1 > b1, a1 == b1, a1 < b1};
        s2_reg <= s1_reg;
    end

    // Pulses start on the chosen instance and counts busy cycles (bounded).
    task automatic run_sweep(input bit inst, input int pulse_at, output int cycles);
        @(negedge clk);
        if (inst) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        cycles = 0;
        while ((inst ? busy1 : busy0) && cycles < 3000) begin
            cycles++;
            if (inst && cycles == pulse_at) start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy0, done0, pass0, err0, a0, b0, fa0, fb0, ff0} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b pass=%b err=%0d a=%h b=%h fa=%h fb=%h ff=%b want all 0",
                     busy0, done0, pass0, err0, a0, b0, fa0, fb0, ff0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: busy=%b done=%b err=%0d", busy0, done0, err0);
    endtask

    task automatic test_sweep(input int m, input int exp_err, input logic [3:0] exp_fa,
                              input logic [3:0] exp_fb, input logic [2:0] exp_ff);
        int cyc;
        mode = m;
        run_sweep(1'b0, 0, cyc);
        checks++;
        if (cyc !== 256) begin failures++; $display("FAIL mode%0d_busy_cycles got %0d want 256", m, cyc); end
        checks++;
        if (done0 !== 1'b1 || pass0 !== (exp_err == 0)) begin
            failures++;
            $display("FAIL mode%0d_done_pass got done=%b pass=%b want done=1 pass=%b", m, done0, pass0, exp_err == 0);
        end
        checks++;
        if (err0 !== 9'(exp_err)) begin failures++; $display("FAIL mode%0d_err_count got %0d want %0d", m, err0, exp_err); end
        checks++;
        if ({fa0, fb0, ff0} !== {exp_fa, exp_fb, exp_ff}) begin
            failures++;
            $display("FAIL mode%0d_first_fail got a=%h b=%h flags=%b want a=%h b=%h flags=%b",
                     m, fa0, fb0, ff0, exp_fa, exp_fb, exp_ff);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({done0, busy0, a0, b0} !== {1'b1, 1'b0, 4'hF, 4'hF}) begin
            failures++;
            $display("FAIL mode%0d_hold got done=%b busy=%b a=%h b=%h want done=1 busy=0 a=f b=f", m, done0, busy0, a0, b0);
        end
        $display("sweep mode=%0d: cycles=%0d err=%0d pass=%b first=(%h,%h,%b)", m, cyc, err0, pass0, fa0, fb0, ff0);
    endtask

    task automatic test_latency2_ignored_start();
        int cyc;
        run_sweep(1'b1, 100, cyc);
        checks++;
        if (cyc !== 768) begin failures++; $display("FAIL lat2_busy_cycles got %0d want 768", cyc); end
        checks++;
        if ({done1, pass1, err1, fa1, fb1, ff1} !== {1'b1, 1'b1, 9'd0, 4'h0, 4'h0, 3'b000}) begin
            failures++;
            $display("FAIL lat2_result got done=%b pass=%b err=%0d fa=%h fb=%h ff=%b want done=1 pass=1 err=0 first=0",
                     done1, pass1, err1, fa1, fb1, ff1);
        end
        $display("latency2 sweep: cycles=%0d err=%0d pass=%b", cyc, err1, pass1);
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        mode = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n = 1;
        while (n < 50) begin n++; @(negedge clk); end
        checks++;
        if ({busy0, a0, b0} !== {1'b1, 4'h3, 4'h1}) begin
            failures++;
            $display("FAIL mid_sweep_progress got busy=%b a=%h b=%h want busy=1 a=3 b=1", busy0, a0, b0);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy0, done0, pass0, err0, a0, b0, fa0, fb0, ff0} !== '0) begin
            failures++;
            $display("FAIL async_reset_outputs got busy=%b done=%b pass=%b err=%0d a=%h b=%h want all 0",
                     busy0, done0, pass0, err0, a0, b0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy0, a0, b0} !== '0) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%b a=%h b=%h want 0", busy0, a0, b0);
        end
        $display("reset mid-sweep: busy=%b a=%h b=%h", busy0, a0, b0);
        test_sweep(0, 0, 4'h0, 4'h0, 3'b000);
    endtask

    initial begin
        test_reset();
        test_sweep(0, 0, 4'h0, 4'h0, 3'b000);
        test_sweep(1, 120, 4'h1, 4'h0, 3'b000);
        // With gt/lt swapped, the first mismatch in sweep order is a=0,b=1 (observed 100).
        test_sweep(2, 240, 4'h0, 4'h1, 3'b100);
        test_sweep(3, 256, 4'h0, 4'h0, 3'b111);
        test_latency2_ignored_start();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
